// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the M-stage data-memory access unit: FSM states,
// store sizes, an empty write mask, and the load funct3 codes.
package dmem_access_unit_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_REQ  = 2'd1,
      DMEM_RESP = 2'd2,
      DMEM_DONE = 2'd3
   } dmem_state_e;

   localparam logic [1:0] ST_SIZE_B = 2'b00;
   localparam logic [1:0] ST_SIZE_H = 2'b01;
   localparam logic [1:0] ST_SIZE_W = 2'b10;

   localparam logic [3:0] WMASK_NONE = 4'b0000;

   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;

endpackage

// File: rtl/dmem_load_extract.sv
// Selects the addressed byte or halfword from a read word and applies
// sign or zero extension according to the load funct3.
module dmem_load_extract
   import dmem_access_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  ld_size_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      shifted = word_i >> {offset_i, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = offset_i[1] ? word_i[31:16] : word_i[15:0];
      case (ld_size_i)
         FNC_LB:  data_o = {{24{byte_v[7]}}, byte_v};
         FNC_LH:  data_o = {{16{half_v[15]}}, half_v};
         FNC_LW:  data_o = word_i;
         FNC_LBU: data_o = {24'd0, byte_v};
         FNC_LHU: data_o = {16'd0, half_v};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data-memory responder: validates and aligns load/store requests,
// runs the request/response handshake and stalls the pipeline until done.
//
//   state | meaning
//   IDLE  | waiting for a load/store intent; checks alignment and size
//   REQ   | mem_req_valid high, holding request until mem_req_ready
//   RESP  | read accepted, waiting for mem_resp_valid
//   DONE  | access finished, stall low for one cycle so the pipeline advances
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int MEM_AW = 30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_re,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        st_size,
   input  logic [2:0]        ld_size,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              access_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [MEM_AW-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data
);

   dmem_state_e       state_q, state_d;
   logic              valid_q, valid_d;
   logic              rw_q, rw_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        ldsz_q, ldsz_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              err_q, err_d;

   logic              has_req;
   logic              err_now;
   logic [3:0]        st_mask;
   logic [31:0]       st_data;
   logic [31:0]       ext_data;

   assign has_req = req_re | req_we;

   // A store takes priority when both intents are raised.
   always_comb begin
      err_now = 1'b0;
      if (req_we) begin
         case (st_size)
            ST_SIZE_B: err_now = 1'b0;
            ST_SIZE_H: err_now = req_addr[0];
            ST_SIZE_W: err_now = |req_addr[1:0];
            default:   err_now = 1'b1;
         endcase
      end else begin
         case (ld_size)
            FNC_LB, FNC_LBU: err_now = 1'b0;
            FNC_LH, FNC_LHU: err_now = req_addr[0];
            FNC_LW:          err_now = |req_addr[1:0];
            default:         err_now = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (st_size)
         ST_SIZE_B: begin
            st_mask = 4'b0001 << req_addr[1:0];
            st_data = {4{req_wdata[7:0]}};
         end
         ST_SIZE_H: begin
            st_mask = 4'b0011 << req_addr[1:0];
            st_data = {2{req_wdata[15:0]}};
         end
         default: begin
            st_mask = 4'b1111;
            st_data = req_wdata;
         end
      endcase
   end

   dmem_load_extract u_extract (
      .word_i    (mem_resp_data),
      .offset_i  (off_q),
      .ld_size_i (ldsz_q),
      .data_o    (ext_data)
   );

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      off_d       = off_q;
      ldsz_d      = ldsz_q;
      load_data_d = load_data_q;
      err_d       = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (has_req) begin
               if (err_now) begin
                  err_d = 1'b1;
               end else begin
                  addr_d  = req_addr[MEM_AW+1:2];
                  rw_d    = req_we;
                  off_d   = req_addr[1:0];
                  ldsz_d  = ld_size;
                  wdata_d = st_data;
                  wmask_d = req_we ? st_mask : WMASK_NONE;
                  valid_d = 1'b1;
                  state_d = DMEM_REQ;
               end
            end
         end
         DMEM_REQ: begin
            if (mem_req_ready) begin
               valid_d = 1'b0;
               state_d = rw_q ? DMEM_DONE : DMEM_RESP;
            end
         end
         DMEM_RESP: begin
            if (mem_resp_valid) begin
               load_data_d = ext_data;
               state_d     = DMEM_DONE;
            end
         end
         default: state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= DMEM_IDLE;
         valid_q     <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= WMASK_NONE;
         off_q       <= '0;
         ldsz_q      <= '0;
         load_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         off_q       <= off_d;
         ldsz_q      <= ldsz_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
      end
   end

   assign stall = (state_q == DMEM_REQ) | (state_q == DMEM_RESP) |
                  ((state_q == DMEM_IDLE) & has_req & ~err_now);

   assign load_data     = load_data_q;
   assign access_err    = err_q;
   assign mem_req_valid = valid_q;
   assign mem_req_rw    = rw_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: expected requests and load results
// are queued at issue time and checked as the DUT handshakes and completes.
module tb_dmem_access_unit;

   localparam int MEM_AW = 30;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_re, req_we;
   logic [31:0]       req_addr, req_wdata;
   logic [1:0]        st_size;
   logic [2:0]        ld_size;
   logic              stall;
   logic [31:0]       load_data;
   logic              access_err;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_rw;
   logic [MEM_AW-1:0] mem_req_addr;
   logic [31:0]       mem_req_wdata;
   logic [3:0]        mem_req_wmask;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_data;

   always #5 clk = ~clk;

   dmem_access_unit #(.MEM_AW(MEM_AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_re         (req_re),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .st_size        (st_size),
      .ld_size        (ld_size),
      .stall          (stall),
      .load_data      (load_data),
      .access_err     (access_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] ld_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] ld);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (ld)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b010:  return w;
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   // Entered shortly after a rising edge with the DUT in IDLE.
   task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] st, input logic [2:0] ld,
                            input logic [31:0] resp_word, input int rdy_dly, input int resp_dly,
                            input string tag);
      req_t        e;
      int          stall_cnt = 0;
      int          pcnt = 0;
      int          rcnt = 0;
      bit          hs = 0;
      bit          done = 0;
      logic [31:0] exp_ld = 32'd0;
      e.addr = {2'b00, addr[31:2]};
      e.rw   = we;
      if (we) begin
         case (st)
            2'b00: begin e.wmask = 4'b0001 << addr[1:0]; e.wdata = {4{wd[7:0]}}; end
            2'b01: begin e.wmask = 4'b0011 << addr[1:0]; e.wdata = {2{wd[15:0]}}; end
            default: begin e.wmask = 4'b1111; e.wdata = wd; end
         endcase
      end else begin
         e.wmask = 4'b0000;
         e.wdata = 32'd0;
         exp_ld  = ref_ext(resp_word, addr[1:0], ld);
         ld_q.push_back(exp_ld);
      end
      req_q.push_back(e);
      req_re = re; req_we = we; req_addr = addr; req_wdata = wd;
      st_size = st; ld_size = ld; mem_resp_data = resp_word;
      for (int cyc = 0; cyc < 80 && !done; cyc++) begin
         #1;
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         if (!stall) begin
            done = 1;
         end else begin
            stall_cnt++;
            if (mem_req_valid) begin
               chk({tag, " addr"}, {2'b00, mem_req_addr}, req_q[0].addr);
               chk({tag, " rw"}, {31'd0, mem_req_rw}, {31'd0, req_q[0].rw});
               chk({tag, " wmask"}, {28'd0, mem_req_wmask}, {28'd0, req_q[0].wmask});
               if (req_q[0].rw) chk({tag, " wdata"}, mem_req_wdata, req_q[0].wdata);
               if (pcnt >= rdy_dly) begin
                  mem_req_ready = 1'b1;
                  void'(req_q.pop_front());
                  hs = 1;
               end
               pcnt++;
            end else if (hs && !we) begin
               if (rcnt == resp_dly) mem_resp_valid = 1'b1;
               rcnt++;
            end
            @(posedge clk);
         end
      end
      if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
      chk({tag, " stall cycles"}, stall_cnt, 2 + rdy_dly + (we ? 0 : 1 + resp_dly));
      chk({tag, " valid in done"}, {31'd0, mem_req_valid}, 32'd0);
      if (!we && ld_q.size() > 0) chk({tag, " load_data"}, load_data, ld_q.pop_front());
      @(posedge clk); #1;
      req_re = 1'b0; req_we = 1'b0;
      #1;
      chk({tag, " idle stall"}, {31'd0, stall}, 32'd0);
      if (!we) chk({tag, " load_data held"}, load_data, exp_ld);
   endtask

   task automatic do_err(input logic re, input logic we, input logic [31:0] addr,
                         input logic [1:0] st, input logic [2:0] ld, input string tag);
      req_re = re; req_we = we; req_addr = addr; req_wdata = 32'h1234_5678;
      st_size = st; ld_size = ld;
      #1;
      chk({tag, " stall"}, {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk({tag, " access_err"}, {31'd0, access_err}, 32'd1);
      chk({tag, " no valid"}, {31'd0, mem_req_valid}, 32'd0);
      req_re = 1'b0; req_we = 1'b0;
      @(posedge clk); #1;
      chk({tag, " err one pulse"}, {31'd0, access_err}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req_re = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      st_size = 2'b00; ld_size = 3'b000;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      #1;
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst access_err", {31'd0, access_err}, 32'd0);
      chk("rst valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst rw", {31'd0, mem_req_rw}, 32'd0);
      chk("rst wmask", {28'd0, mem_req_wmask}, 32'd0);
      chk("rst addr", {2'b00, mem_req_addr}, 32'd0);
      chk("rst wdata", mem_req_wdata, 32'd0);
      chk("rst load_data", load_data, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      do_access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 2'b10, 3'b010, 32'h0, 0, 0, "SW");
      do_access(1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 2'b00, 3'b010, 32'h0, 0, 0, "SB");
      do_access(1'b0, 1'b1, 32'h0000_0102, 32'h0000_1234, 2'b01, 3'b010, 32'h0, 2, 0, "SH");
      do_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, 2'b00, 3'b000, 32'h1280_FF00, 0, 3, "LB");
      do_access(1'b1, 1'b0, 32'h0000_0202, 32'h0, 2'b00, 3'b101, 32'h1280_FF00, 0, 0, "LHU");
      do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 2'b00, 3'b001, 32'h1280_FF00, 1, 1, "LH");
      do_access(1'b1, 1'b0, 32'h0000_0201, 32'h0, 2'b00, 3'b100, 32'h1280_FF00, 0, 0, "LBU");
      do_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, 2'b00, 3'b010, 32'h89AB_CDEF, 0, 2, "LW");
      do_access(1'b1, 1'b1, 32'h0000_0108, 32'hCAFE_F00D, 2'b10, 3'b010, 32'h0, 0, 0, "RE+WE");

      do_err(1'b1, 1'b0, 32'h0000_0006, 2'b00, 3'b010, "LW mis");
      do_err(1'b0, 1'b1, 32'h0000_0101, 2'b01, 3'b000, "SH mis");
      do_err(1'b0, 1'b1, 32'h0000_0100, 2'b11, 3'b000, "ST size11");
      do_err(1'b1, 1'b0, 32'h0000_0100, 2'b00, 3'b011, "LD fnc011");
      do_err(1'b1, 1'b0, 32'h0000_0203, 2'b00, 3'b001, "LH mis");

      // Read held off by ready, then reset while waiting for the response.
      req_re = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; st_size = 2'b00; ld_size = 3'b010;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("RST-LW valid", {31'd0, mem_req_valid}, 32'd1);
         chk("RST-LW addr", {2'b00, mem_req_addr}, 32'h0000_0040);
         chk("RST-LW rw", {31'd0, mem_req_rw}, 32'd0);
         chk("RST-LW wmask", {28'd0, mem_req_wmask}, 32'd0);
         chk("RST-LW stall", {31'd0, stall}, 32'd1);
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      chk("RST-LW resp wait valid", {31'd0, mem_req_valid}, 32'd0);
      chk("RST-LW resp wait stall", {31'd0, stall}, 32'd1);
      #2;
      reset = 1'b1; req_re = 1'b0;
      #1;
      chk("RST-LW async stall", {31'd0, stall}, 32'd0);
      chk("RST-LW async valid", {31'd0, mem_req_valid}, 32'd0);
      @(negedge clk); reset = 1'b0;
      mem_resp_data = 32'hCAFE_BABE; mem_resp_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      chk("RST-LW late resp load_data", load_data, 32'd0);
      chk("RST-LW late resp stall", {31'd0, stall}, 32'd0);
      chk("RST-LW late resp valid", {31'd0, mem_req_valid}, 32'd0);

      do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2'b00, 3'b010, 32'h1122_3344, 0, 0, "LW after rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
